gmux_switch_seq: RTL and testbench
==================================

// Module: gmux_switch_seq
// PURPOSE
//  Control-side sequencer for the global clock mux. It drives the mux select (SSEL) and the per-quadrant
//  gate/enable controls (SEN/DYNEN/DEN/VLP), so a clock-source switch is always performed with quadrants
//  gated and settled. Sits in fabric, clocked by a free-running clock independent of both mux inputs.
// PARAMETERS
//  SETTLE_CYCLES  4        cycles held gated before and after SSEL changes; legal range 1..255
//  QUAD_MASK      4'b1111  quadrants under control, bit order {BR,BL,TR,TL}; masked-off bits drive 0
//  (localparam) CNT_W = $clog2(SETTLE_CYCLES+1)
// PORTS
//  QCK      in   1  sequencer clock
//  QRT      in   1  reset, synchronous, active-high
//  REQ      in   1  switch request, sampled only in IDLE
//  REQ_SEL  in   1  target source: 0 = GCLKIN, 1 = GHSCK
//  LP_REQ   in   4  per-quadrant low-power request {BR,BL,TR,TL}
//  BUSY     out  1  high while a switch sequence is in progress
//  ACK      out  1  one-cycle pulse when a request completes
//  SSEL     out  1  mux select, registered
//  SEN      out  4  static enable (= QUAD_MASK)
//  DYNEN    out  4  dynamic-gate enable (= QUAD_MASK)
//  DEN      out  4  dynamic disable/gate, 1 = quadrant gated
//  VLP      out  4  quadrant very-low-power, 1 = powered down
// BEHAVIOUR
//  - All outputs are registered. Reset values: SSEL=0, DEN=0, VLP=0, BUSY=0, ACK=0, state=IDLE.
//    SEN and DYNEN are constants.
//  - Reset takes effect at the next QCK edge and applies in every state. A reset mid-sequence aborts
//    the sequence with no ACK.
//  - FSM: IDLE -> GATE -> SETTLE_A -> SWITCH -> SETTLE_B -> UNGATE -> DONE -> IDLE.
//  - Edges are numbered from e0, the edge at which IDLE samples REQ=1 with REQ_SEL != SSEL:
//    e0: DEN <= QUAD_MASK, BUSY <= 1, target latched
//    e(S+1): SSEL <= target
//    e(2S+2): DEN <= VLP-held bits only
//    e(2S+3): ACK <= 1 for exactly one cycle, BUSY <= 0
//    S = SETTLE_CYCLES. REQ-to-ACK latency is 2S+4 cycles.
//  - Fast path: REQ=1 with REQ_SEL == SSEL in IDLE goes IDLE -> DONE. ACK follows the next edge;
//    DEN and SSEL are untouched.
//  - REQ and REQ_SEL changes while BUSY=1 are ignored and not queued. REQ held high re-triggers in IDLE,
//    so the requester must drop REQ on ACK.
//  - A quadrant with VLP=1 always has DEN=1, including after UNGATE.
//  - The settle counter loads S-1 on entering SETTLE_A/B and decrements to 0. It never wraps.
// CONFIGURATION
//  GMUX_SEQ_LP_EN defined:
//    VLP[i] <= LP_REQ[i] & QUAD_MASK[i], updated only in IDLE.
//    Entering low power sets DEN[i] on the same edge. Leaving low power clears VLP first; DEN[i] falls
//    one edge later.
//  GMUX_SEQ_LP_EN undefined:
//    VLP tied 0 and LP_REQ ignored (unconnected).
// STRUCTURE
//  - gmux_seq_pkg: state enum typedef; quadrant index constants QTL=0, QTR=1, QBL=2, QBR=3.
//  - Sub-module gmux_seq_timer: loadable down-counter, CNT_W bits, with a zero flag.
//  - The top holds the FSM and output registers.
// TESTING
//  1. Reset: assert QRT for 2 cycles -> SSEL=0, DEN=0, VLP=0, BUSY=0, ACK=0; SEN=DYNEN=4'b1111.
//  2. S=4, REQ=1, REQ_SEL=1 at e0 -> DEN=4'hF after e0; SSEL=1 after e5; DEN=0 after e10;
//     ACK pulse after e11; BUSY high e0..e11.
//  3. Fast path: SSEL=1, REQ_SEL=1 -> ACK after e1; DEN stays 0; no SSEL edge.
//  4. Second REQ with REQ_SEL=0 at e3 of a busy sequence -> ignored; single ACK; SSEL=1 at end.
//  5. QRT asserted at e7 of a sequence -> SSEL=0, DEN=0, state IDLE after e7; no ACK.
//  6. LP_EN: LP_REQ=4'b0100 in IDLE -> VLP=4'b0100, DEN=4'b0100. Run a switch -> DEN returns to
//     4'b0100, not 0. LP_EN off: VLP stays 0.
//  - Check SSEL changes only while DEN==QUAD_MASK, in every sequence.

Source files
------------

// File: rtl/gmux_seq_pkg.sv
// Shared types and constants for the global clock mux switch sequencer.
// Quadrant bit order everywhere is {BR,BL,TR,TL}.
package gmux_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GATE     = 3'd1,
        S_SETTLE_A = 3'd2,
        S_SWITCH   = 3'd3,
        S_SETTLE_B = 3'd4,
        S_UNGATE   = 3'd5,
        S_DONE     = 3'd6
    } gmux_state_e;

    localparam int QTL = 0;
    localparam int QTR = 1;
    localparam int QBL = 2;
    localparam int QBR = 3;

    // Restrict a per-quadrant vector to the quadrants this sequencer controls.
    function automatic logic [3:0] quad_lp_mask(input logic [3:0] req, input logic [3:0] mask);
        logic [3:0] r;
        r      = '0;
        r[QTL] = req[QTL] & mask[QTL];
        r[QTR] = req[QTR] & mask[QTR];
        r[QBL] = req[QBL] & mask[QBL];
        r[QBR] = req[QBR] & mask[QBR];
        return r;
    endfunction

endpackage

// File: rtl/gmux_seq_timer.sv
// Loadable settle down-counter for the clock mux sequencer.
// Saturates at zero; zero flag is combinational from the count register.
module gmux_seq_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gmux_switch_seq.sv
// Global clock mux switch sequencer: gates quadrants, settles, flips SSEL, settles, ungates.
// Optional low-power quadrant control is enabled by defining GMUX_SEQ_LP_EN.
module gmux_switch_seq
    import gmux_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  QUAD_MASK     = 4'b1111
) (
    input  logic       QCK,
    input  logic       QRT,
    input  logic       REQ,
    input  logic       REQ_SEL,
    input  logic [3:0] LP_REQ,
    output logic       BUSY,
    output logic       ACK,
    output logic       SSEL,
    output logic [3:0] SEN,
    output logic [3:0] DYNEN,
    output logic [3:0] DEN,
    output logic [3:0] VLP
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] IDLE     = S_IDLE;
    localparam logic [2:0] GATE     = S_GATE;
    localparam logic [2:0] SETTLE_A = S_SETTLE_A;
    localparam logic [2:0] SWITCH   = S_SWITCH;
    localparam logic [2:0] SETTLE_B = S_SETTLE_B;
    localparam logic [2:0] UNGATE   = S_UNGATE;
    localparam logic [2:0] DONE     = S_DONE;

    logic [2:0] state;
    logic       target;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_zero;
    logic [3:0] vlp_next;

`ifdef GMUX_SEQ_LP_EN
    assign vlp_next = quad_lp_mask(LP_REQ, QUAD_MASK);
`else
    logic lp_req_unused;
    assign lp_req_unused = ^LP_REQ;
    assign vlp_next      = 4'b0000;
`endif

    assign SEN   = QUAD_MASK;
    assign DYNEN = QUAD_MASK;

    assign timer_load = (state == GATE) || (state == SWITCH);
    assign timer_dec  = ((state == SETTLE_A) || (state == SETTLE_B)) && !timer_zero;

    gmux_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (QCK),
        .rst     (QRT),
        .load    (timer_load),
        .load_val(LOAD_VAL),
        .dec     (timer_dec),
        .zero    (timer_zero)
    );

    // In IDLE, DEN is the union of old and new VLP so a quadrant is gated before
    // it powers down and stays gated one edge after it powers back up.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state  <= IDLE;
            target <= 1'b0;
            BUSY   <= 1'b0;
            ACK    <= 1'b0;
            SSEL   <= 1'b0;
            DEN    <= 4'b0000;
            VLP    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    ACK <= 1'b0;
                    VLP <= vlp_next;
                    if (REQ && (REQ_SEL != SSEL)) begin
                        DEN    <= QUAD_MASK;
                        BUSY   <= 1'b1;
                        target <= REQ_SEL;
                        state  <= GATE;
                    end else begin
                        DEN <= VLP | vlp_next;
                        if (REQ) begin
                            state <= DONE;
                        end
                    end
                end
                GATE: begin
                    state <= SETTLE_A;
                end
                SETTLE_A: begin
                    if (timer_zero) begin
                        SSEL  <= target;
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    state <= SETTLE_B;
                end
                SETTLE_B: begin
                    if (timer_zero) begin
                        DEN   <= quad_lp_mask(VLP, QUAD_MASK);
                        state <= UNGATE;
                    end
                end
                UNGATE: begin
                    ACK   <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    // A full sequence arrives here with ACK already raised; the fast path raises it here.
                    if (ACK) begin
                        ACK   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ACK <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmux_switch_seq.sv
// Scoreboard bench for gmux_switch_seq: expected snapshots and ACK events are queued by the
// stimulus side and matched by an independent negedge monitor.
module tb_gmux_switch_seq;

    localparam int         S    = 4;
    localparam logic [3:0] MASK = 4'b1111;

    typedef struct {
        int         cyc;
        logic       ssel;
        logic [3:0] den;
        logic [3:0] vlp;
        logic       busy;
    } exp_t;

    logic       QCK = 1'b0;
    logic       QRT = 1'b1;
    logic       REQ = 1'b0;
    logic       REQ_SEL = 1'b0;
    logic [3:0] LP_REQ = 4'b0000;
    logic       BUSY, ACK, SSEL;
    logic [3:0] SEN, DYNEN, DEN, VLP;

    int   compared = 0;
    int   mismatched = 0;
    int   edge_cnt = 0;
    logic rst_edge = 1'b1;
    logic monitor_on = 1'b0;
    logic prev_ssel = 1'b0;

    exp_t snap_q[$];
    exp_t ack_q[$];

    logic       m_ssel = 1'b0;
    logic [3:0] lp_cur = 4'b0000;

    gmux_switch_seq #(
        .SETTLE_CYCLES(S),
        .QUAD_MASK    (MASK)
    ) dut (
        .QCK    (QCK),
        .QRT    (QRT),
        .REQ    (REQ),
        .REQ_SEL(REQ_SEL),
        .LP_REQ (LP_REQ),
        .BUSY   (BUSY),
        .ACK    (ACK),
        .SSEL   (SSEL),
        .SEN    (SEN),
        .DYNEN  (DYNEN),
        .DEN    (DEN),
        .VLP    (VLP)
    );

    always #5 QCK = ~QCK;

    always @(posedge QCK) begin
        edge_cnt = edge_cnt + 1;
        rst_edge = QRT;
    end

    function automatic logic [3:0] modelVlp(input logic [3:0] lp);
`ifdef GMUX_SEQ_LP_EN
        return lp & MASK;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, actual, expected);
        end
    endtask

    task automatic pushSnap(input int cyc, input logic ssel, input logic [3:0] den,
                            input logic [3:0] vlp, input logic busy);
        exp_t e;
        e.cyc = cyc; e.ssel = ssel; e.den = den; e.vlp = vlp; e.busy = busy;
        snap_q.push_back(e);
    endtask

    task automatic pushAck(input int cyc, input logic ssel, input logic [3:0] den, input logic [3:0] vlp);
        exp_t e;
        e.cyc = cyc; e.ssel = ssel; e.den = den; e.vlp = vlp; e.busy = 1'b0;
        ack_q.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge; the following edge samples them.
    task automatic drive(input logic req, input logic sel, input logic [3:0] lp, input logic rst);
        @(posedge QCK);
        #1;
        REQ = req; REQ_SEL = sel; LP_REQ = lp; QRT = rst;
    endtask

    // Issue one request; poke names the edge (relative to e0) that sees an opposite-target REQ.
    task automatic applyStimulus(input logic sel, input int poke);
        int         c;
        logic [3:0] v;
        drive(1'b1, sel, lp_cur, 1'b0);
        c = edge_cnt + 1;
        v = modelVlp(lp_cur);
        if (sel != m_ssel) begin
            pushSnap(c, m_ssel, MASK, v, 1'b1);
            pushSnap(c + S, m_ssel, MASK, v, 1'b1);
            pushSnap(c + S + 1, sel, MASK, v, 1'b1);
            pushSnap(c + 2*S + 1, sel, MASK, v, 1'b1);
            pushSnap(c + 2*S + 2, sel, v, v, 1'b1);
            pushAck(c + 2*S + 3, sel, v, v);
            m_ssel = sel;
            for (int i = 0; i < 2*S + 4; i++) begin
                if (i + 1 == poke) drive(1'b1, ~sel, lp_cur, 1'b0);
                else drive(1'($urandom % 2), 1'($urandom % 2), lp_cur, 1'b0);
            end
        end else begin
            pushSnap(c, m_ssel, v, v, 1'b0);
            pushAck(c + 1, sel, v, v);
            for (int i = 0; i < 2; i++) drive(1'($urandom % 2), 1'($urandom % 2), lp_cur, 1'b0);
        end
    endtask

    task automatic lpChange(input logic [3:0] lp);
        int         k;
        logic [3:0] vo, vn;
        vo = modelVlp(lp_cur);
        vn = modelVlp(lp);
        drive(1'b0, 1'b0, lp, 1'b0);
        k = edge_cnt + 1;
        pushSnap(k, m_ssel, vo | vn, vn, 1'b0);
        pushSnap(k + 1, m_ssel, vn, vn, 1'b0);
        drive(1'b0, 1'b0, lp, 1'b0);
        lp_cur = lp;
    endtask

    // Abort a sequence with reset at e7; LP_REQ must already be 0 so VLP stays 0 after reset.
    task automatic resetMid();
        int   c;
        logic sel;
        sel = ~m_ssel;
        drive(1'b1, sel, lp_cur, 1'b0);
        c = edge_cnt + 1;
        pushSnap(c, m_ssel, MASK, 4'b0000, 1'b1);
        pushSnap(c + S + 1, sel, MASK, 4'b0000, 1'b1);
        for (int i = 1; i < 7; i++) drive(1'b0, 1'b0, lp_cur, 1'b0);
        drive(1'b0, 1'b0, lp_cur, 1'b1);
        pushSnap(c + 7, 1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 1'b0, lp_cur, 1'b0);
        m_ssel = 1'b0;
    endtask

    always @(negedge QCK) begin
        if (monitor_on) begin
            while (snap_q.size() > 0 && snap_q[0].cyc == edge_cnt) begin
                exp_t s;
                s = snap_q.pop_front();
                checkOutput("snap_ssel", 32'(SSEL), 32'(s.ssel));
                checkOutput("snap_den", 32'(DEN), 32'(s.den));
                checkOutput("snap_vlp", 32'(VLP), 32'(s.vlp));
                checkOutput("snap_busy", 32'(BUSY), 32'(s.busy));
            end
            if (ACK) begin
                if (ack_q.size() == 0) begin
                    checkOutput("ack_unexpected", 32'(ACK), 32'd0);
                end else begin
                    exp_t a;
                    a = ack_q.pop_front();
                    checkOutput("ack_edge", 32'(edge_cnt), 32'(a.cyc));
                    checkOutput("ack_ssel", 32'(SSEL), 32'(a.ssel));
                    checkOutput("ack_den", 32'(DEN), 32'(a.den));
                    checkOutput("ack_vlp", 32'(VLP), 32'(a.vlp));
                    checkOutput("ack_busy", 32'(BUSY), 32'd0);
                end
            end
            if (ack_q.size() > 0 && ack_q[0].cyc < edge_cnt) begin
                exp_t m;
                m = ack_q.pop_front();
                checkOutput("ack_missing", 32'(ACK), 32'd1);
            end
            if (SSEL !== prev_ssel && !rst_edge) begin
                checkOutput("ssel_gated", 32'(DEN), 32'(MASK));
            end
        end
        prev_ssel = SSEL;
    end

    initial begin
        drive(1'b0, 1'b0, 4'b0000, 1'b1);
        @(negedge QCK);
        checkOutput("rst_ssel", 32'(SSEL), 32'd0);
        checkOutput("rst_den", 32'(DEN), 32'd0);
        checkOutput("rst_vlp", 32'(VLP), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_ack", 32'(ACK), 32'd0);
        checkOutput("rst_sen", 32'(SEN), 32'(MASK));
        checkOutput("rst_dynen", 32'(DYNEN), 32'(MASK));
        monitor_on = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 1'b0);

        applyStimulus(1'b1, -1);
        applyStimulus(1'b1, -1);
        applyStimulus(1'b0, -1);
        applyStimulus(1'b1, 3);
        lpChange(4'b0100);
        applyStimulus(1'b0, -1);
        lpChange(4'b0000);
        applyStimulus(1'b1, -1);
        resetMid();

        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                applyStimulus(1'($urandom % 2), -1);
            end else if (r < 7) begin
                lpChange(4'($urandom));
            end else begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) drive(1'b0, 1'b0, lp_cur, 1'b0);
            end
        end

        for (int j = 0; j < 6; j++) drive(1'b0, 1'b0, lp_cur, 1'b0);
        @(negedge QCK);
        checkOutput("snap_left", 32'(snap_q.size()), 32'd0);
        checkOutput("ack_left", 32'(ack_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
